// File: rtl/temporizador_multizona.sv
// temporizador_multizona: per-zone absence timer with warning window and one-shot shutdown pulse
module temporizador_multizona #(
    parameter int N_ZONES = 4,
    parameter int TIMEOUT = 30000,
    parameter int WARN_T  = 5000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONES-1:0] enable,
    input  logic [N_ZONES-1:0] presence,
    input  logic [N_ZONES-1:0] force_off,
    output logic [N_ZONES-1:0] shutdown,
    output logic [N_ZONES-1:0] warn,
    output logic [N_ZONES-1:0] lights_on,
    output logic               shutdown_any
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WARN_AT = CW'(TIMEOUT - WARN_T - 1);

    typedef enum logic [2:0] {IDLE, COUNT, WARN, FIRE, OFF} state_t;

    for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
        state_t        st, st_n;
        logic [CW-1:0] cnt, cnt_n;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st  <= IDLE;
                cnt <= '0;
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
            end
        end

        // With WARN_T=0, WARN_AT equals LAST, so the FIRE test shadows the WARN entry
        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            case (st)
                IDLE, COUNT, WARN: begin
                    cnt_n = '0;
                    if (!enable[g] || (!force_off[g] && presence[g])) st_n = IDLE;
                    else if (force_off[g]) st_n = FIRE;
                    else if (st == IDLE) st_n = COUNT;
                    else if (cnt == LAST) st_n = FIRE;
                    else begin
                        cnt_n = cnt + 1'b1;
                        if (st == COUNT && cnt == WARN_AT) st_n = WARN;
                    end
                end
                FIRE: begin
                    st_n  = OFF;
                    cnt_n = '0;
                end
                OFF: begin
                    cnt_n = '0;
                    if (presence[g] || !enable[g]) st_n = IDLE;
                end
                default: begin
                    st_n  = IDLE;
                    cnt_n = '0;
                end
            endcase
        end

        assign shutdown[g]  = st == FIRE;
        assign warn[g]      = st == WARN;
        assign lights_on[g] = st == IDLE || st == COUNT || st == WARN;
    end

    assign shutdown_any = |shutdown;
endmodule

// File: doc/temporizador_multizona.md
TEMPORIZADOR_MULTIZONA -- requirements
Module: temporizador_multizona

Interface
REQ-001 The block SHALL have parameter N_ZONES, default 4: number of independent zones (>=1).
REQ-002 The block SHALL have parameter TIMEOUT, default 30000: cycles of continuous absence before shutdown (>=2).
REQ-003 The block SHALL have parameter WARN_T, default 5000: length in cycles of the pre-shutdown warning window (0..TIMEOUT-1; 0 = no warning).
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port enable, input, N_ZONES bits: per-zone automatic-shutdown enable.
REQ-007 The block SHALL have port presence, input, N_ZONES bits: per-zone infrared presence, 1 = occupied.
REQ-008 The block SHALL have port force_off, input, N_ZONES bits: per-zone manual shutdown request.
REQ-009 The block SHALL have port shutdown, output, N_ZONES bits: one-cycle shutdown pulse per zone.
REQ-010 The block SHALL have port warn, output, N_ZONES bits: per-zone warning, high during the warning window.
REQ-011 The block SHALL have port lights_on, output, N_ZONES bits: per-zone light command.
REQ-012 The block SHALL have port shutdown_any, output, 1 bit: OR of all shutdown bits.

Function
REQ-013 Each zone SHALL have an independent FSM {IDLE, COUNT, WARN, FIRE, OFF} and a counter cnt of width $clog2(TIMEOUT).
REQ-014 Outputs SHALL be Moore decodes of the registered state: shutdown=1 only in FIRE; warn=1 only in WARN; lights_on=1 in IDLE/COUNT/WARN, 0 in FIRE/OFF; shutdown_any combinational OR.
REQ-015 Transition priority in IDLE/COUNT/WARN SHALL be: !enable -> IDLE (cnt<=0); else force_off -> FIRE (cnt<=0); else presence -> IDLE (cnt<=0); else timing rules below.
REQ-016 IDLE: cnt held at 0; enable & !presence & !force_off -> COUNT with cnt=0 on the first COUNT cycle.
REQ-017 COUNT/WARN: if cnt==TIMEOUT-1 -> FIRE, cnt<=0; else cnt<=cnt+1.
REQ-018 COUNT -> WARN on the edge where cnt+1==TIMEOUT-WARN_T; with WARN_T=0 WARN is never entered.
REQ-019 Total cycles spent in COUNT+WARN before FIRE SHALL be exactly TIMEOUT; WARN lasts exactly WARN_T cycles.
REQ-020 FIRE SHALL last exactly one cycle, then -> OFF unconditionally (force_off, presence, enable ignored in FIRE).
REQ-021 OFF: cnt held 0; presence or !enable -> IDLE; otherwise stay OFF; force_off ignored; no repeated shutdown pulses while unoccupied.
REQ-022 cnt SHALL never exceed TIMEOUT-1 and SHALL never wrap.
REQ-023 Zones SHALL not interact; simultaneous events in different zones SHALL be handled in the same cycle.

Reset
REQ-024 While rst=1, every zone SHALL be in IDLE with cnt=0: shutdown=0, warn=0, lights_on=all ones, shutdown_any=0.
REQ-025 Reset asserted mid-operation (any state) SHALL force REQ-024 values immediately, without waiting for clk; first transition after release on the next rising edge.

Verification (TIMEOUT=10, WARN_T=3, N_ZONES=4; edge 0 = first edge sampling the stimulus)
REQ-026 rst pulse during arbitrary activity -> shutdown=0000, warn=0000, lights_on=1111 asynchronously.
REQ-027 Zone0 enable=1, presence=0 held from edge 0 -> warn[0]=1 after edges 7,8,9 only; shutdown[0]=1 and shutdown_any=1 for one cycle after edge 10; lights_on[0]=0 from edge 10 onward, no further pulse.
REQ-028 As REQ-027 with presence[0] pulsed one cycle at edge 8 -> warn[0] drops after edge 8, no shutdown; recount restarts; shutdown after edge 19 if presence stays 0.
REQ-029 Zone1 in COUNT, force_off[1]=1 and presence[1]=1 same cycle -> FIRE next cycle (force_off wins), then OFF; OFF exits to IDLE when presence[1]=1.
REQ-030 Zones 2 and 3 started same edge -> both shutdown bits high same single cycle, shutdown_any=1 once; enable[2] dropped during WARN -> zone2 IDLE next edge, zone3 unaffected.
